fetch_unit: RTL and testbench

//   Instruction fetch stage, directly upstream of the exmem program RAM.
//   - Generates the PC and drives exmem.pcaddr.
//   - Accepts exmem.instruction, which returns 1 cycle after pcaddr is sampled.
//   - Presents {instr, instr_pc} to decode with a valid/ready handshake.
//   - A 1-entry skid buffer absorbs decode stalls without bubbles.
//   - Also handles branch redirects and a HALT instruction.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits in front of the exmem program RAM. It
//   generates the PC, receives the RAM read data one cycle later, and hands
//   {instr, instr_pc} to decode over a valid/ready handshake. A 1-entry skid
//   register absorbs decode stalls without inserting bubbles. The stage also
//   handles branch redirects and stops fetching on a HALT instruction.
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset_n      in   async active-low reset
//   pcaddr       out  registered fetch address to exmem
//   instruction  in   exmem read data = ram[pcaddr sampled at previous edge]
//   instr        out  instruction presented to decode
//   instr_pc     out  address of instr
//   instr_valid  out  instr/instr_pc are valid
//   decode_ready in   decode accepts; transfer = instr_valid & decode_ready
//   redirect     in   branch/jump taken, 1-cycle pulse
//   redirect_pc  in   redirect target address
//   halted       out  fetch stopped on HALT_INSTR
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                     WIDTH         = 16,
    parameter int                     RAM_ADDR_BITS = 13,
    parameter logic [RAM_ADDR_BITS-1:0] RESET_PC    = '0,
    parameter logic [WIDTH-1:0]       HALT_INSTR    = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [RAM_ADDR_BITS-1:0] pcaddr,
    input  logic [WIDTH-1:0]         instruction,
    output logic [WIDTH-1:0]         instr,
    output logic [RAM_ADDR_BITS-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     decode_ready,
    input  logic                     redirect,
    input  logic [RAM_ADDR_BITS-1:0] redirect_pc,
    output logic                     halted
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_SKID,
        ST_FLUSH,
        ST_HALT
    } state_t;

    state_t                     r_state;
    logic [RAM_ADDR_BITS-1:0]   r_pcaddr;
    logic [RAM_ADDR_BITS-1:0]   r_instr_pc;
    logic [WIDTH-1:0]           r_skid_instr;
    logic                       r_valid;
    logic                       r_halted;

    logic                       w_transfer;
    logic                       w_is_halt;

    // In SKID the RAM output already belongs to the next address, so the
    // stalled instruction must come from the skid register.
    assign instr       = (r_state == ST_SKID) ? r_skid_instr : instruction;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign pcaddr      = r_pcaddr;

    assign w_transfer  = r_valid & decode_ready;
    assign w_is_halt   = (instr == HALT_INSTR);

    // r_instr_pc always names the address whose data is being presented:
    // it is loaded with the outgoing pcaddr on every edge that issues the
    // fetch which will be presented next, and simply holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_BOOT;
            r_pcaddr     <= RESET_PC;
            r_instr_pc   <= '0;
            // NOTE: the skid register is a plain flop, so it is reset like any
            // other state; a mid-run reset must never surface stale contents.
            r_skid_instr <= '0;
            r_valid      <= 1'b0;
            r_halted     <= 1'b0;
        end else if (redirect) begin
            // Redirect outranks everything: the in-flight fetch and the skid
            // entry are abandoned and one bubble cycle follows.
            r_pcaddr <= redirect_pc;
            r_state  <= ST_FLUSH;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register
            // sees pre-edge values, independent of statement order.
            unique case (r_state)
                ST_BOOT, ST_FLUSH: begin
                    r_instr_pc <= r_pcaddr;
                    r_pcaddr   <= r_pcaddr + RAM_ADDR_BITS'(1);
                    r_state    <= ST_RUN;
                    r_valid    <= 1'b1;
                end
                ST_RUN, ST_SKID: begin
                    if (w_transfer && w_is_halt) begin
                        // pcaddr is left where it is; only redirect resumes.
                        r_state  <= ST_HALT;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_transfer) begin
                        r_instr_pc <= r_pcaddr;
                        r_pcaddr   <= r_pcaddr + RAM_ADDR_BITS'(1);
                        r_state    <= ST_RUN;
                    end else if (r_state == ST_RUN) begin
                        // Capture the stalled word; pcaddr holds, so the RAM
                        // keeps re-reading the next address for the exit edge.
                        r_skid_instr <= instruction;
                        r_state      <= ST_SKID;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural program RAM answers the
//   fetches; a stream-level reference model (next expected address, pending
//   bubble, halted flag) predicts what decode must see every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int              W     = 16;
    localparam int              A     = 13;
    localparam logic [A-1:0]    RST_PC = '0;
    localparam logic [W-1:0]    HALT  = '0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [A-1:0]  pcaddr;
    logic [W-1:0]  instruction = '0;
    logic [W-1:0]  instr;
    logic [A-1:0]  instr_pc;
    logic          instr_valid;
    logic          decode_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [A-1:0]  redirect_pc = '0;
    logic          halted;

    fetch_unit #(
        .WIDTH         (W),
        .RAM_ADDR_BITS (A),
        .RESET_PC      (RST_PC),
        .HALT_INSTR    (HALT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pcaddr       (pcaddr),
        .instruction  (instruction),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .decode_ready (decode_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Program RAM: synchronous read of the address presented at each edge.
    logic [W-1:0] mem [0:(1<<A)-1];
    always @(posedge clk) instruction <= mem[pcaddr];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the delivered stream.
    logic [A-1:0] m_pc;       // address of the next instruction decode should get
    bit           m_bubble;   // one dead cycle pending (after reset or redirect)
    bit           m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, check outputs, advance the model for
    // the coming posedge, and return at the following negedge.
    task automatic step(input bit rdy, input bit redir, input logic [A-1:0] rpc);
        bit exp_valid;
        decode_ready = rdy;
        redirect     = redir;
        redirect_pc  = rpc;
        exp_valid = !m_bubble && !m_halted;
        check("valid", 32'(instr_valid), 32'(exp_valid));
        check("halted", 32'(halted), 32'(m_halted));
        if (exp_valid) begin
            check("instr_pc", 32'(instr_pc), 32'(m_pc));
            check("instr", 32'(instr), 32'(mem[m_pc]));
        end
        if (redir) begin
            m_pc     = rpc;
            m_bubble = 1'b1;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (rdy) begin
            if (mem[m_pc] == HALT) m_halted = 1'b1;
            else                   m_pc = m_pc + 1'b1;
        end
        @(negedge clk);
    endtask

    // Called at a negedge: asserts reset asynchronously, reloads the RAM and
    // returns at a negedge with reset released.
    task automatic do_reset(input int fill);
        decode_ready = 1'b0;
        redirect     = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pcaddr", 32'(pcaddr), 32'(RST_PC));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        for (int i = 0; i < (1 << A); i++) begin
            if (fill == 2) mem[i] = ($urandom_range(0, 49) == 0) ? HALT : W'($urandom_range(1, 16'hFFFF));
            else           mem[i] = W'(16'h1000 + i);
        end
        if (fill == 1) mem[3] = HALT;
        m_pc     = RST_PC;
        m_bubble = 1'b1;
        m_halted = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);

        // Linear stream from reset, then a 3-cycle stall while pc 5 is shown.
        do_reset(0);
        repeat (6) step(1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        repeat (4) step(1'b1, 1'b0, '0);

        // Redirect while stalled in the skid state.
        repeat (2) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 13'h0100);
        repeat (4) step(1'b1, 1'b0, '0);

        // Redirect near the top of the address space to exercise PC wrap.
        step(1'b1, 1'b1, 13'h1FFE);
        repeat (6) step(1'b1, 1'b0, '0);

        // Reset asserted mid-stall while pc 7 is held.
        step(1'b0, 1'b1, 13'h0007);
        repeat (3) step(1'b0, 1'b0, '0);
        do_reset(0);
        repeat (6) step(1'b1, 1'b0, '0);

        // HALT at address 3, then a redirect to 0 resumes fetching.
        do_reset(1);
        repeat (15) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 13'h0000);
        repeat (6) step(1'b1, 1'b0, '0);

        // Randomized traffic: random ready, occasional redirects and halts.
        for (int r = 0; r < 3; r++) begin
            do_reset(2);
            for (int c = 0; c < 1500; c++) begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     A'($urandom_range(0, (1 << A) - 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
